otter_intrpt_ctrl: RTL and testbench

- Interrupt aggregation stage directly upstream of the control-unit FSM.
- Collects NUM_SRC asynchronous external interrupt lines, synchronises them, and latches edge events into pending bits.
- Applies per-source and global enables and priority-selects one source.
- Drives a clean level intrpt_vld and a stable cause id into the core; retires the serviced request when the FSM reports intrpt_taken.

---
 rtl/otter_intrpt_ctrl.sv | 137 +++++++++++++
 tb/tb_otter_intrpt_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_intrpt_ctrl.sv
// rtl/otter_intrpt_ctrl.sv - interrupt synchroniser, pending latch and priority request stage feeding the CU FSM
module otter_intrpt_ctrl #(
    parameter int                 NUM_SRC     = 4,
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_SRC-1:0] EDGE_MASK   = {NUM_SRC{1'b1}},
    parameter int                 ID_W        = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_en,
    input  logic               mie,
    input  logic               intrpt_taken,
    input  logic               pend_clr_vld,
    input  logic [NUM_SRC-1:0] pend_clr_mask,
    output logic               intrpt_vld,
    output logic [ID_W-1:0]    intrpt_id,
    output logic [NUM_SRC-1:0] pending
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] s;
    logic [NUM_SRC-1:0] s_d;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pend_edge_q;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] sel_mask;
    logic [NUM_SRC-1:0] ack_mask;
    logic               any_req;
    logic               cur_req;
    logic               ack;
    logic               id_load;
    logic [ID_W-1:0]    win_id;
    state_t             state;
    state_t             state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= '0;
            end
            s_d <= '0;
        end else begin
            sync_q[0] <= irq_src;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
            s_d <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

    // A new edge beats a simultaneous clear so no event is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_edge_q <= '0;
        end else begin
            pend_edge_q <= (rise | (pend_edge_q & ~clr)) & EDGE_MASK;
        end
    end

    assign pending = (pend_edge_q & EDGE_MASK) | (s & ~EDGE_MASK);
    assign req     = pending & irq_en;
    assign any_req = mie & (|req);

    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_mask[i] = (intrpt_id == ID_W'(i));
        end
    end

    // Lowest index wins; scanning downward leaves the smallest set index.
    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    assign ack      = (state == ST_ASSERT) & intrpt_taken;
    assign ack_mask = sel_mask & {NUM_SRC{ack}};
    assign clr      = ({NUM_SRC{pend_clr_vld}} & pend_clr_mask) | ack_mask;
    assign cur_req  = |(req & sel_mask);

    always_comb begin
        state_nxt = state;
        id_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_ASSERT;
                    id_load   = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (intrpt_taken) begin
                    state_nxt = ST_HOLDOFF;
                end else if (!cur_req || !mie) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLDOFF: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            intrpt_vld <= 1'b0;
            intrpt_id  <= '0;
        end else begin
            state      <= state_nxt;
            intrpt_vld <= (state_nxt == ST_ASSERT);
            if (id_load) begin
                intrpt_id <= win_id;
            end
        end
    end

endmodule

// File: tb/tb_otter_intrpt_ctrl.sv
// tb/tb_otter_intrpt_ctrl.sv - self-checking bench for otter_intrpt_ctrl (edge and mixed level/edge instances)
module tb_otter_intrpt_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_src;
    logic [3:0] irq_en;
    logic       mie;
    logic       intrpt_taken;
    logic       pend_clr_vld;
    logic [3:0] pend_clr_mask;
    logic       vld_e, vld_l;
    logic [3:0] id_e, id_l;
    logic [3:0] pend_e, pend_l;

    int  total = 0;
    int  bad = 0;
    bit  cmp_en = 1'b0;

    always #5 clk = ~clk;

    otter_intrpt_ctrl dut_e (
        .clk(clk), .rst(rst), .irq_src(irq_src), .irq_en(irq_en), .mie(mie),
        .intrpt_taken(intrpt_taken), .pend_clr_vld(pend_clr_vld), .pend_clr_mask(pend_clr_mask),
        .intrpt_vld(vld_e), .intrpt_id(id_e), .pending(pend_e)
    );

    otter_intrpt_ctrl #(.EDGE_MASK(4'b1110)) dut_l (
        .clk(clk), .rst(rst), .irq_src(irq_src), .irq_en(irq_en), .mie(mie),
        .intrpt_taken(intrpt_taken), .pend_clr_vld(pend_clr_vld), .pend_clr_mask(pend_clr_mask),
        .intrpt_vld(vld_l), .intrpt_id(id_l), .pending(pend_l)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] mask_of(input int m);
        logic [7:0] masks;
        masks = 8'hEF;
        return masks[m*4 +: 4];
    endfunction

    function automatic logic [3:0] lowest_set(input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            if (r[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    // Reference: samples history (newest first), latched edge events, and per-instance request status.
    logic [3:0] m_smp [$];
    logic [3:0] m_pe   [2];
    logic [3:0] m_id   [2];
    bit         m_asrt [2];
    bit         m_hold [2];
    logic [3:0] ms, msd, mrise, mvis, mreq, mclr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_smp = '{4'h0, 4'h0, 4'h0};
            for (int m = 0; m < 2; m++) begin
                m_pe[m] = 4'h0; m_id[m] = 4'h0; m_asrt[m] = 1'b0; m_hold[m] = 1'b0;
            end
        end else begin
            ms    = m_smp[1];
            msd   = m_smp[2];
            mrise = ms & ~msd;
            for (int m = 0; m < 2; m++) begin
                mvis = (m_pe[m] & mask_of(m)) | (ms & ~mask_of(m));
                mreq = mvis & irq_en;
                mclr = pend_clr_vld ? pend_clr_mask : 4'h0;
                if (m_asrt[m] && intrpt_taken) mclr[m_id[m]] = 1'b1;
                m_pe[m] = (mrise | (m_pe[m] & ~mclr)) & mask_of(m);
                if (m_asrt[m]) begin
                    if (intrpt_taken) begin
                        m_asrt[m] = 1'b0;
                        m_hold[m] = 1'b1;
                    end else if (!mreq[m_id[m]] || !mie) begin
                        m_asrt[m] = 1'b0;
                    end
                end else if (m_hold[m]) begin
                    m_hold[m] = 1'b0;
                end else if (mie && mreq != 4'h0) begin
                    m_asrt[m] = 1'b1;
                    m_id[m]   = lowest_set(mreq);
                end
            end
            m_smp.push_front(irq_src);
            void'(m_smp.pop_back());
        end
    end

    logic       o_vld  [2];
    logic [3:0] o_id   [2];
    logic [3:0] o_pend [2];
    assign o_vld[0] = vld_e;  assign o_id[0] = id_e;  assign o_pend[0] = pend_e;
    assign o_vld[1] = vld_l;  assign o_id[1] = id_l;  assign o_pend[1] = pend_l;

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("model_vld%0d", m), o_vld[m], m_asrt[m]);
                chk($sformatf("model_id%0d", m), o_id[m], m_id[m]);
                chk($sformatf("model_pend%0d", m), o_pend[m],
                    (m_pe[m] & mask_of(m)) | (m_smp[1] & ~mask_of(m)));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        irq_src = 4'h0; irq_en = 4'h0; mie = 1'b0; intrpt_taken = 1'b0;
        pend_clr_vld = 1'b0; pend_clr_mask = 4'h0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 cmp_en = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("reset_vld", vld_e, 1'b0);
        chk("reset_id", id_e, 4'h0);
        chk("reset_pend", pend_e, 4'h0);
        tick(2);

        // basic edge: 3-edge latency then ack
        irq_en = 4'b0001; mie = 1'b1; irq_src = 4'b0001;
        tick(1); irq_src = 4'h0;
        tick(2);
        chk("basic_pend", pend_e, 4'b0001);
        chk("basic_vld_early", vld_e, 1'b0);
        tick(1);
        chk("basic_vld", vld_e, 1'b1);
        chk("basic_id", id_e, 4'd0);
        intrpt_taken = 1'b1;
        tick(1); intrpt_taken = 1'b0;
        chk("basic_holdoff", vld_e, 1'b0);
        chk("basic_pend_clr", pend_e, 4'h0);
        tick(1);
        chk("basic_stay_low", vld_e, 1'b0);
        tick(3);

        // priority and back-to-back
        irq_en = 4'hF; irq_src = 4'b0110;
        tick(1); irq_src = 4'h0;
        tick(3);
        chk("prio_vld", vld_e, 1'b1);
        chk("prio_id1", id_e, 4'd1);
        intrpt_taken = 1'b1;
        tick(1); intrpt_taken = 1'b0;
        chk("prio_gap", vld_e, 1'b0);
        chk("prio_pend", pend_e, 4'b0100);
        tick(2);
        chk("prio_id2", id_e, 4'd2);
        chk("prio_vld2", vld_e, 1'b1);
        intrpt_taken = 1'b1;
        tick(1); intrpt_taken = 1'b0;
        chk("prio_pend_empty", pend_e, 4'h0);
        tick(3);

        // masking and retract
        mie = 1'b0; irq_src = 4'b1000;
        tick(1); irq_src = 4'h0;
        tick(3);
        chk("mask_vld", vld_e, 1'b0);
        chk("mask_pend", pend_e, 4'b1000);
        mie = 1'b1;
        tick(1);
        chk("mask_vld_on", vld_e, 1'b1);
        chk("mask_id3", id_e, 4'd3);
        irq_en = 4'b0111;
        tick(1);
        chk("retract_vld", vld_e, 1'b0);
        chk("retract_pend", pend_e, 4'b1000);
        pend_clr_vld = 1'b1; pend_clr_mask = 4'b1000;
        tick(1); pend_clr_vld = 1'b0; pend_clr_mask = 4'h0;
        chk("swclr_pend", pend_e, 4'h0);
        irq_en = 4'hF;
        tick(3);

        // set/clear collision on source 0
        irq_src = 4'b0001;
        tick(1); irq_src = 4'h0;
        tick(1); irq_src = 4'b0001;
        tick(1); irq_src = 4'h0;
        tick(1);
        chk("coll_vld", vld_e, 1'b1);
        intrpt_taken = 1'b1;
        tick(1); intrpt_taken = 1'b0;
        chk("coll_pend_kept", pend_e, 4'b0001);
        chk("coll_vld_low", vld_e, 1'b0);
        tick(2);
        chk("coll_reassert", vld_e, 1'b1);
        chk("coll_id", id_e, 4'd0);
        intrpt_taken = 1'b1;
        tick(1); intrpt_taken = 1'b0;
        tick(3);

        // level source on the mixed instance
        irq_src = 4'b0001;
        tick(3);
        chk("lvl_vld", vld_l, 1'b1);
        chk("lvl_id", id_l, 4'd0);
        intrpt_taken = 1'b1;
        tick(1); intrpt_taken = 1'b0;
        chk("lvl_holdoff", vld_l, 1'b0);
        chk("lvl_pend_held", pend_l, 4'b0001);
        tick(2);
        chk("lvl_reassert", vld_l, 1'b1);
        irq_src = 4'h0;
        tick(1);
        chk("lvl_pend_lag", pend_l, 4'b0001);
        tick(1);
        chk("lvl_pend_gone", pend_l, 4'h0);
        pend_clr_vld = 1'b1; pend_clr_mask = 4'hF;
        tick(1); pend_clr_vld = 1'b0; pend_clr_mask = 4'h0;
        tick(4);

        // async reset while asserted
        irq_src = 4'b0001;
        tick(1); irq_src = 4'h0;
        n = 0;
        while (!vld_e && n < 10) begin
            tick(1);
            n++;
        end
        chk("arst_wait_vld", vld_e, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", vld_e, 1'b0);
        chk("arst_pend", pend_e, 4'h0);
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("arst_quiet", vld_e, 1'b0);
        end

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick(1);
            rst = 1'b0;
            if ($urandom_range(0, 3) == 0) irq_src = 4'($urandom);
            if ($urandom_range(0, 15) == 0) irq_en = 4'($urandom);
            if ($urandom_range(0, 15) == 0) mie = ($urandom_range(0, 7) != 0);
            if (vld_e || vld_l) intrpt_taken = ($urandom_range(0, 2) == 0);
            else intrpt_taken = ($urandom_range(0, 15) == 0);
            pend_clr_vld  = ($urandom_range(0, 15) == 0);
            pend_clr_mask = 4'($urandom);
            if ($urandom_range(0, 499) == 0) #1 rst = 1'b1;
        end
        tick(1);
        rst = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
